key_event_ctrl: RTL and testbench



---
 rtl/key_pkg.sv | 25 ++
 rtl/key_debounce.sv | 55 +++++
 rtl/key_event_ctrl.sv | 105 ++++++++++
 tb/tb_key_event_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and default timing constants for the front-panel key controller.
// Defaults assume a 50 MHz sys_clk.
package key_pkg;

  localparam int unsigned DEB_W = 20;
  localparam int unsigned TMR_W = 26;

  localparam logic [DEB_W-1:0] DEB_MAX_DEF  = 20'd999_999;     // 20 ms
  localparam logic [TMR_W-1:0] LONG_MAX_DEF = 26'd49_999_999;  // 1 s
  localparam logic [TMR_W-1:0] DBL_MAX_DEF  = 26'd14_999_999;  // 300 ms

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPress1   = 3'd1,
    StLongHold = 3'd2,
    StGap      = 3'd3,
    StPress2   = 3'd4
  } key_state_e;

  // Saturating increment so a forgotten state can never wrap back into a match.
  function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] t);
    return (&t) ? t : t + TMR_W'(1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser and counter debouncer for one active-low key.
// Produces the debounced level plus one-cycle press/release pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter logic [DEB_W-1:0] DEB_MAX = DEB_MAX_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_ni,
  output logic key_level_o,
  output logic press_p_o,
  output logic release_p_o
);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             key_sync;

  always_comb begin
    sync_d   = {sync_q[0], key_ni};
    key_sync = sync_q[1];
    level_d  = level_q;
    cnt_d    = '0;
    if (key_sync != level_q) begin
      if (cnt_q == DEB_MAX) begin
        level_d = key_sync;
      end else begin
        cnt_d = cnt_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q      <= 2'b11;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      cnt_q       <= '0;
    end else begin
      sync_q      <= sync_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
    end
  end

  assign key_level_o = level_q;
  // Pulses fire in the first cycle the debounced level shows its new value.
  assign press_p_o   = level_dly_q & ~level_q;
  assign release_p_o = ~level_dly_q & level_q;

endmodule

// File: rtl/key_event_ctrl.sv
// Key gesture classifier: debounced key -> short / long / double-click flags.
// Each gesture produces exactly one registered single-cycle flag.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter logic [DEB_W-1:0] DEB_MAX  = DEB_MAX_DEF,
  parameter logic [TMR_W-1:0] LONG_MAX = LONG_MAX_DEF,
  parameter logic [TMR_W-1:0] DBL_MAX  = DBL_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_level,
  output logic short_flag,
  output logic long_flag,
  output logic double_flag,
  output logic busy
);

  logic press_p, release_p;

  key_debounce #(
    .DEB_MAX (DEB_MAX)
  ) u_debounce (
    .clk_i       (sys_clk),
    .rst_i       (sys_rst),
    .key_ni      (key_in),
    .key_level_o (key_level),
    .press_p_o   (press_p),
    .release_p_o (release_p)
  );

  key_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             dbl_q, dbl_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (press_p) state_d = StPress1;
      end
      StPress1: begin
        // A release on the same cycle as the timeout still counts as a short click.
        if (release_p) begin
          state_d = StGap;
        end else if (timer_q == LONG_MAX) begin
          state_d = StLongHold;
          long_d  = 1'b1;
        end
      end
      StLongHold: begin
        if (release_p) state_d = StIdle;
      end
      StGap: begin
        if (press_p) begin
          state_d = StPress2;
        end else if (timer_q == DBL_MAX) begin
          state_d = StIdle;
          short_d = 1'b1;
        end
      end
      StPress2: begin
        if (release_p) begin
          state_d = StIdle;
          dbl_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    timer_d = (state_d != state_q) ? '0 : tmr_inc(timer_q);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      busy_q  <= busy_d;
    end
  end

  assign short_flag  = short_q;
  assign long_flag   = long_q;
  assign double_flag = dbl_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl with DEB_MAX=3, LONG_MAX=20, DBL_MAX=10.
// Expected flags (kind, clock edge) are queued at stimulus time and matched by a monitor.
module tb_key_event_ctrl;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key_in  = 1'b1;
  logic key_level, short_flag, long_flag, double_flag, busy;

  key_event_ctrl #(
    .DEB_MAX  (20'd3),
    .LONG_MAX (26'd20),
    .DBL_MAX  (26'd10)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_in      (key_in),
    .key_level   (key_level),
    .short_flag  (short_flag),
    .long_flag   (long_flag),
    .double_flag (double_flag),
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Rising edges seen so far; at a negedge this is the index of the last edge.
  int edge_n = 0;
  always @(posedge sys_clk) edge_n <= edge_n + 1;

  typedef enum int {KShort = 0, KLong = 1, KDouble = 2} kind_e;
  typedef struct {
    kind_e kind;
    int    at;
  } exp_t;
  // Offsets are edges from the first key_in drive low to the flag edge.
  // key_in -> key_level takes 6 edges (2 sync + DEB_MAX+1).
  typedef struct {
    int    h1;
    int    gap;
    int    h2;
    kind_e kind;
    int    off;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  always @(negedge sys_clk) begin
    int    nf;
    kind_e seen;
    exp_t  e;
    if (mon_en) begin
      nf = $countones({short_flag, long_flag, double_flag});
      if (nf != 0) begin
        seen = short_flag ? KShort : (long_flag ? KLong : KDouble);
        if (nf > 1) begin
          check("one_flag_at_a_time", nf, 1);
        end else if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_flag: got kind %0d at edge %0d, expected none", seen, edge_n);
        end else begin
          e = sb.pop_front();
          check("flag_kind", int'(seen), int'(e.kind));
          check("flag_edge", edge_n, e.at);
          check("busy_at_flag", int'(busy), (seen == KLong) ? 1 : 0);
        end
      end
    end
  end

  task automatic gesture(input vec_t v);
    exp_t e;
    key_in = 1'b0;
    e.kind = v.kind;
    e.at   = edge_n + v.off;
    sb.push_back(e);
    step(v.h1);
    key_in = 1'b1;
    if (v.gap > 0) begin
      step(v.gap);
      key_in = 1'b0;
      step(v.h2);
      key_in = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 400) begin
      step(1);
      k++;
    end
    check({name, "_drain"}, sb.size(), 0);
    sb.delete();
    step(25);
    check({name, "_busy_idle"}, int'(busy), 0);
    check({name, "_level_idle"}, int'(key_level), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   t0, nf;
    exp_t e;

    vecs[0] = '{10, 0, 0, KShort, 28};   // short press
    vecs[1] = '{15, 0, 0, KShort, 33};
    vecs[2] = '{40, 0, 0, KLong, 28};    // long press, release gives nothing
    vecs[3] = '{22, 0, 0, KLong, 28};    // release one cycle after timeout
    vecs[4] = '{21, 0, 0, KShort, 39};   // release_p on PRESS1 timer == 20
    vecs[5] = '{5, 4, 5, KDouble, 21};   // double click
    vecs[6] = '{5, 11, 5, KDouble, 28};  // press_p on GAP timer == 10
    vecs[7] = '{5, 4, 40, KDouble, 56};  // long second hold is ignored

    step(3);
    sys_rst = 1'b0;
    check("rst_level", int'(key_level), 1);
    check("rst_short", int'(short_flag), 0);
    check("rst_long", int'(long_flag), 0);
    check("rst_double", int'(double_flag), 0);
    check("rst_busy", int'(busy), 0);
    mon_en = 1'b1;
    step(5);

    // Bounce: low 3, high 2, then held low.
    key_in = 1'b0;
    t0     = edge_n;
    e.kind = KShort;
    e.at   = t0 + 33;
    sb.push_back(e);
    step(3);
    key_in = 1'b1;
    step(2);
    key_in = 1'b0;           // reaches key_sync at t0+7
    step(5);
    check("bounce_level_hold", int'(key_level), 1);
    step(1);
    check("bounce_level_fall", int'(key_level), 0);
    check("bounce_busy_pre", int'(busy), 0);
    step(1);
    check("bounce_busy", int'(busy), 1);
    step(3);
    key_in = 1'b1;
    drain("bounce");

    foreach (vecs[i]) begin
      gesture(vecs[i]);
      drain($sformatf("vec%0d", i));
    end

    // Second press just past the double window: short, then a fresh short gesture.
    key_in = 1'b0;
    t0     = edge_n;
    e.kind = KShort;
    e.at   = t0 + 23;
    sb.push_back(e);
    e.at   = t0 + 40;
    sb.push_back(e);
    step(5);
    key_in = 1'b1;
    step(12);
    key_in = 1'b0;
    step(5);
    key_in = 1'b1;
    drain("late_second");

    // Reset while in GAP aborts the gesture silently.
    key_in = 1'b0;
    step(5);
    key_in = 1'b1;
    step(9);
    check("gap_busy", int'(busy), 1);
    sys_rst = 1'b1;
    step(1);
    sys_rst = 1'b0;
    check("gap_rst_level", int'(key_level), 1);
    check("gap_rst_busy", int'(busy), 0);
    check("gap_rst_flags", int'({short_flag, long_flag, double_flag}), 0);
    nf = 0;
    repeat (30) begin
      step(1);
      nf += $countones({short_flag, long_flag, double_flag});
    end
    check("gap_rst_no_flag", nf, 0);
    check("gap_rst_busy_after", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
